// File: rtl/datapath_29.sv
// Register-transfer datapath for the 3-bit sequencing controller: counter A, flags E/F, done, s1 count, conflict flag.
// Optional macro DP_SAT_EN: A saturates at all-ones on s1 instead of wrapping.
module datapath_29 #(
    parameter int WIDTH = 4,
    parameter int E_BIT = 2,
    parameter int F_BIT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             done,
    output logic [7:0]       inc_cnt,
    output logic             err
);

    logic [WIDTH-1:0] a_q, a_d, a_inc;
    logic             e_q, e_d;
    logic             f_q, f_d;
    logic             done_q, done_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [4:0]       sel;
    logic             multi_sel;

    assign sel       = {s4, s3, s2, s1, s0};
    assign multi_sel = (sel & (sel - 5'd1)) != 5'd0;

`ifdef DP_SAT_EN
    assign a_inc = (&a_q) ? a_q : a_q + WIDTH'(1);
`else
    assign a_inc = a_q + WIDTH'(1);
`endif

    always_comb begin
        a_d    = a_q;
        e_d    = e_q;
        f_d    = f_q;
        cnt_d  = cnt_q;
        err_d  = err_q | multi_sel;
        // done tracks "s4 was the executed action on this edge"
        done_d = 1'b0;
        if (s0) begin
            a_d   = '0;
            f_d   = 1'b0;
            cnt_d = 8'd0;
        end else if (s1) begin
            a_d   = a_inc;
            e_d   = a_inc[E_BIT];
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 8'd1;
        end else if (s2) begin
            if (a_q[F_BIT]) f_d = 1'b1;
        end else if (s3) begin
            e_d = 1'b0;
        end else if (s4) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            e_q    <= 1'b0;
            f_q    <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            e_q    <= e_d;
            f_q    <= f_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign A       = a_q;
    assign E       = e_q;
    assign F       = f_q;
    assign done    = done_q;
    assign inc_cnt = cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_datapath_29.sv
// Scoreboard bench for datapath_29: a behavioural model pushes expected outputs per driven cycle, popped after the edge.
module tb_datapath_29;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             s0 = 0, s1 = 0, s2 = 0, s3 = 0, s4 = 0;
    logic [WIDTH-1:0] A;
    logic             E, F, done, err;
    logic [7:0]       inc_cnt;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic             e;
        logic             f;
        logic             done;
        logic [7:0]       cnt;
        logic             err;
    } exp_t;

    exp_t sb[$];

    int m_a, m_e, m_f, m_done, m_cnt, m_err;
    int errors = 0;
    int checks = 0;

    datapath_29 #(.WIDTH(WIDTH), .E_BIT(2), .F_BIT(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .s0      (s0),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3),
        .s4      (s4),
        .A       (A),
        .E       (E),
        .F       (F),
        .done    (done),
        .inc_cnt (inc_cnt),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_e = 0; m_f = 0; m_done = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_update(input logic [4:0] sel);
        int n;
        if ($countones(sel) > 1) m_err = 1;
        m_done = (sel == 5'b10000) ? 1 : 0;
        if (sel[0]) begin
            m_a = 0; m_f = 0; m_cnt = 0;
        end else if (sel[1]) begin
            n = m_a + 1;
`ifdef DP_SAT_EN
            if (n == 16) n = 15;
`else
            if (n == 16) n = 0;
`endif
            m_a = n;
            m_e = (n / 4) % 2;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (sel[2]) begin
            if (m_a >= 8) m_f = 1;
        end else if (sel[3]) begin
            m_e = 0;
        end
    endtask

    task automatic step(input logic [4:0] sel, input string tag);
        exp_t x, got;
        @(negedge clock);
        {s4, s3, s2, s1, s0} = sel;
        model_update(sel);
        x.a = WIDTH'(m_a); x.e = m_e[0]; x.f = m_f[0];
        x.done = m_done[0]; x.cnt = 8'(m_cnt); x.err = m_err[0];
        sb.push_back(x);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        check({tag, ".A"},    32'(A),       32'(got.a));
        check({tag, ".E"},    32'(E),       32'(got.e));
        check({tag, ".F"},    32'(F),       32'(got.f));
        check({tag, ".done"}, 32'(done),    32'(got.done));
        check({tag, ".cnt"},  32'(inc_cnt), 32'(got.cnt));
        check({tag, ".err"},  32'(err),     32'(got.err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".A"},    32'(A),       32'd0);
        check({tag, ".E"},    32'(E),       32'd0);
        check({tag, ".F"},    32'(F),       32'd0);
        check({tag, ".done"}, 32'(done),    32'd0);
        check({tag, ".cnt"},  32'(inc_cnt), 32'd0);
        check({tag, ".err"},  32'(err),     32'd0);
    endtask

    // Assert reset part-way through a low phase, check outputs before any edge, release later.
    task automatic mid_reset(input string tag);
        @(negedge clock);
        {s4, s3, s2, s1, s0} = 5'b0;
        #2 reset = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 check_zero("por");
        @(negedge clock);
        reset = 1'b0;

        step(5'b00001, "s0");
        for (int i = 0; i < 4; i++) step(5'b00010, "cnt");
        for (int i = 0; i < 4; i++) step(5'b00010, "to8");
        step(5'b00100, "f_set");
        for (int i = 0; i < 3; i++) step(5'b10000, "hold");
        step(5'b01000, "s3");
        for (int i = 0; i < 7; i++) step(5'b00010, "to15");
        step(5'b00010, "wrap");
        step(5'b00000, "idle");
        for (int i = 0; i < 5; i++) step(5'b00010, "to5");
        check("pre_rst.F", 32'(F), 32'd1);
        mid_reset("mid_rst");

        step(5'b00001, "s0b");
        for (int i = 0; i < 7; i++) step(5'b00010, "to7");
        step(5'b00100, "f_keep");

        step(5'b00001, "s0c");
        for (int i = 0; i < 6; i++) step(5'b00010, "to6");
        step(5'b00011, "conf01");
        step(5'b00001, "s0_sticky");
        step(5'b01100, "conf23");
        step(5'b10010, "conf14");
        mid_reset("rst_err");

        step(5'b00001, "s0d");
        for (int i = 0; i < 260; i++) step(5'b00010, "sat");
        step(5'b10000, "done1");
        step(5'b00001, "done_drop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_29.md
Name: datapath_29

Overview:
- Register-transfer datapath that sits directly downstream of the structural 3-bit controller.
- Consumes the controller's one-hot state-decode outputs and executes the register transfers for each state: counter A, flags E and F.
- Returns status E and F to the controller, where they feed the next-state logic.
- All state updates occur on the rising clock edge; the block holds no combinational loop back to the controller.

Parameters:
- WIDTH, 4, width of counter A (min 3).
- E_BIT, 2, bit index of A sampled into E on increment (must be < WIDTH).
- F_BIT, 3, bit index of A tested for setting F (must be < WIDTH).

Ports:
- clock  input  1  rising-edge clock, shared with controller.
- reset  input  1  asynchronous, active-high; clears all state.
- s0  input  1  controller state 0 (idle): clear A and F.
- s1  input  1  controller state 1: increment A, update E.
- s2  input  1  controller state 2: set F if A[F_BIT]=1.
- s3  input  1  controller state 3: clear E.
- s4  input  1  controller state 4: hold (done).
- A  output  WIDTH  counter value.
- E  output  1  flag E (status to controller).
- F  output  1  flag F (status to controller).
- done  output  1  registered; 1 while the controller is in s4.
- inc_cnt  output  8  number of s1 cycles since the last s0; saturates at 255.
- err  output  1  sticky; set when more than one of s0..s4 is high in a cycle.

Behaviour:
- Reset (async, active-high): A=0, E=0, F=0, done=0, inc_cnt=0, err=0, applied immediately regardless of clock. Reset mid-operation discards all state; the first edge after deassertion follows the rules below.
- Per-cycle priority when multiple selects are high: s0 > s1 > s2 > s3 > s4. Only the highest-priority action executes, and err <= 1.
- err clears only on reset.
- No select high: all registers hold, err unchanged.
- s0: A <= 0, F <= 0, inc_cnt <= 0, done <= 0; E holds.
- s1: A <= A+1 (mod 2^WIDTH, wraps all-ones -> 0). E <= bit E_BIT of the incremented value (A+1), not of the old A. inc_cnt <= inc_cnt+1, saturating at 255. done <= 0.
- s2: if A[F_BIT]=1 then F <= 1, else F holds; A and E hold. done <= 0.
- s3: E <= 0; A and F hold. done <= 0.
- s4: done <= 1 on this edge; all else holds. done stays 1 while s4 is high and drops to 0 on the first edge where s4 is low.
- Latency: every transfer is visible on the outputs 1 cycle after the select is sampled. E and F are registered, so the controller sees each update on the following edge.
- Wrap-around: A all-ones with s1 -> A=0, and E takes bit E_BIT of 0, which is 0.
- inc_cnt at 255 with s1: stays 255.

Optional Feature:
- Macro: DP_SAT_EN.
- Defined: A saturates at all-ones on s1 instead of wrapping. E is still updated from the saturated value, and inc_cnt still increments.
- Undefined: A wraps modulo 2^WIDTH as specified above.

Test Plan:
- Reset: assert reset mid-cycle with A=5, E=1, F=1 -> all outputs 0 immediately, before the next clock edge.
- Count sequence: s0 one cycle, then s1 for 4 cycles -> A=1,2,3,4; E=0,0,0,1; inc_cnt=4; F=0.
- F set: continue s1 to A=8, then s2 -> F=1 next cycle. Separately, s2 with A=7 -> F stays 0.
- Wrap: A=15, s1 -> A=0, E=0. With DP_SAT_EN defined -> A=15, E=1.
- Conflict: s0 and s1 high together with A=6 -> A=0, err=1. Then s0 alone -> err stays 1 until reset.
- done/hold: s4 for 3 cycles -> done=1 from the first edge, A/E/F unchanged; s4 low -> done=0 next edge.
